// File: rtl/timer_irq_pkg.sv
// Shared definitions for the timer interrupt scheduler.
// Holds the register map, the interrupt FSM states and the reset pulse width.
package timer_irq_pkg;

    localparam logic [2:0] ADDR_PERIOD_BASE = 3'd0;
    localparam logic [2:0] ADDR_ENABLE      = 3'd4;
    localparam logic [2:0] ADDR_PW          = 3'd5;
    localparam logic [2:0] ADDR_OVR_CLR     = 3'd6;

    localparam int unsigned PW_DEFAULT = 100;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ASSERT   = 2'd1,
        ST_WAIT_ACK = 2'd2
    } irq_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts one position after ptr and wraps modulo N.
// Outputs the winner as both a one-hot vector and an index.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt_onehot,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    always_comb begin
        logic [IDX_W-1:0] cand;
        gnt_onehot = '0;
        gnt_idx    = '0;
        gnt_valid  = 1'b0;
        cand       = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = IDX_W'((32'(ptr) + i) % N);
            if (!gnt_valid && req[cand]) begin
                gnt_valid        = 1'b1;
                gnt_idx          = cand;
                gnt_onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_irq_scheduler.sv
// Periodic timer channels feeding one round-robin-scheduled interrupt line.
// Each interrupt is held high for a programmable pulse width and waits for a CPU ack.
module timer_irq_scheduler #(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned CNT_W      = 24,
    parameter int unsigned PW_W       = 12,
    parameter int unsigned PW_DEFAULT = timer_irq_pkg::PW_DEFAULT
) (
    input  logic                      clk_100,
    input  logic                      rstn_100,
    input  logic                      cfg_we,
    input  logic [2:0]                cfg_addr,
    input  logic [CNT_W-1:0]          cfg_wdata,
    input  logic                      ack,
    input  logic [$clog2(N_CH)-1:0]   ack_id,
    output logic                      irq,
    output logic [$clog2(N_CH)-1:0]   irq_id,
    output logic                      busy,
    output logic [N_CH-1:0]           pending,
    output logic [N_CH-1:0]           overrun
);
    import timer_irq_pkg::*;

    localparam int unsigned ID_W = $clog2(N_CH);

    logic [CNT_W-1:0] period [N_CH];
    logic [CNT_W-1:0] count  [N_CH];
    logic [N_CH-1:0]  enable, ch_active, tick, restart;
    logic [N_CH-1:0]  granted_oh, ack_vec, keep_mask, overrun_clr;
    logic [N_CH-1:0]  pending_nxt, overrun_nxt, gnt_onehot;
    logic [PW_W-1:0]  pw, pw_lat, pw_cnt, pw_cnt_nxt;
    logic [ID_W-1:0]  rr_ptr, gnt_idx;
    logic             gnt_valid, ack_hit, load_grant, irq_nxt;
    irq_state_t       state, state_nxt;

    assign busy    = (state != ST_IDLE);
    assign ack_hit = ack && busy && (ack_id == irq_id);

    always_comb begin
        ch_active = '0;
        tick      = '0;
        restart   = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            ch_active[k] = enable[k] && (period[k] != '0);
            tick[k]      = ch_active[k] && (count[k] == period[k] - CNT_W'(1));
            restart[k]   = cfg_we && ((cfg_addr == ADDR_PERIOD_BASE + 3'(k)) ||
                           (cfg_addr == ADDR_ENABLE && cfg_wdata[k] && !enable[k]));
        end
    end

    // A tick outranks a same-cycle ack, so a fresh event is never lost.
    always_comb begin
        ack_vec     = ack_hit ? granted_oh : '0;
        keep_mask   = busy ? granted_oh : '0;
        overrun_clr = (cfg_we && cfg_addr == ADDR_OVR_CLR) ? cfg_wdata[N_CH-1:0] : '0;
        pending_nxt = (pending | tick) & ~(ack_vec & ~tick) & (enable | keep_mask);
        overrun_nxt = (overrun & ~overrun_clr) | (tick & pending & ~ack_vec);
    end

    always_ff @(posedge clk_100 or negedge rstn_100) begin
        if (!rstn_100) begin
            for (int unsigned k = 0; k < N_CH; k++) begin
                period[k] <= '0;
                count[k]  <= '0;
            end
            enable  <= '0;
            pw      <= PW_W'(PW_DEFAULT);
            pending <= '0;
            overrun <= '0;
        end else begin
            for (int unsigned k = 0; k < N_CH; k++) begin
                if (restart[k] || !ch_active[k] || tick[k])
                    count[k] <= '0;
                else
                    count[k] <= count[k] + CNT_W'(1);
                if (cfg_we && cfg_addr == ADDR_PERIOD_BASE + 3'(k))
                    period[k] <= cfg_wdata;
            end
            if (cfg_we && cfg_addr == ADDR_ENABLE)
                enable <= cfg_wdata[N_CH-1:0];
            if (cfg_we && cfg_addr == ADDR_PW)
                pw <= cfg_wdata[PW_W-1:0];
            pending <= pending_nxt;
            overrun <= overrun_nxt;
        end
    end

    rr_arbiter #(
        .N     (N_CH),
        .IDX_W (ID_W)
    ) u_rr_arbiter (
        .req        (pending),
        .ptr        (rr_ptr),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .gnt_valid  (gnt_valid)
    );

    // irq is registered: ASSERT spends one cycle raising it, then PW cycles high.
    always_comb begin
        state_nxt  = state;
        irq_nxt    = 1'b0;
        load_grant = 1'b0;
        pw_cnt_nxt = pw_cnt;
        unique case (state)
            ST_IDLE: begin
                if (gnt_valid) begin
                    state_nxt  = ST_ASSERT;
                    load_grant = 1'b1;
                    pw_cnt_nxt = '0;
                end
            end
            ST_ASSERT: begin
                if (ack_hit) begin
                    state_nxt = ST_IDLE;
                end else if (irq && pw_cnt == pw_lat - PW_W'(1)) begin
                    state_nxt = ST_WAIT_ACK;
                end else begin
                    irq_nxt = 1'b1;
                    if (irq)
                        pw_cnt_nxt = pw_cnt + PW_W'(1);
                end
            end
            ST_WAIT_ACK: begin
                if (ack_hit)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_100 or negedge rstn_100) begin
        if (!rstn_100) begin
            state      <= ST_IDLE;
            irq        <= 1'b0;
            irq_id     <= '0;
            granted_oh <= '0;
            rr_ptr     <= ID_W'(N_CH - 1);
            pw_lat     <= PW_W'(1);
            pw_cnt     <= '0;
        end else begin
            state  <= state_nxt;
            irq    <= irq_nxt;
            pw_cnt <= pw_cnt_nxt;
            if (load_grant) begin
                irq_id     <= gnt_idx;
                granted_oh <= gnt_onehot;
                rr_ptr     <= gnt_idx;
                pw_lat     <= (pw == '0) ? PW_W'(1) : pw;
            end
        end
    end

endmodule

// File: tb/tb_timer_irq_scheduler.sv
// Directed and randomized bench for timer_irq_scheduler.
// The reference tracks cycles-since-restart per channel and cycles-since-grant for the irq line.
module tb_timer_irq_scheduler;

    localparam int unsigned N_CH  = 4;
    localparam int unsigned CNT_W = 24;
    localparam int unsigned PW_W  = 12;

    logic             clk_100   = 1'b0;
    logic             rstn_100  = 1'b0;
    logic             cfg_we    = 1'b0;
    logic [2:0]       cfg_addr  = '0;
    logic [CNT_W-1:0] cfg_wdata = '0;
    logic             ack       = 1'b0;
    logic [1:0]       ack_id    = '0;
    logic             irq;
    logic [1:0]       irq_id;
    logic             busy;
    logic [N_CH-1:0]  pending;
    logic [N_CH-1:0]  overrun;

    int checks = 0;
    int errors = 0;
    int cyc_no = 0;

    always #5 clk_100 = ~clk_100;

    timer_irq_scheduler #(
        .N_CH       (N_CH),
        .CNT_W      (CNT_W),
        .PW_W       (PW_W),
        .PW_DEFAULT (100)
    ) dut (
        .clk_100   (clk_100),
        .rstn_100  (rstn_100),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .ack       (ack),
        .ack_id    (ack_id),
        .irq       (irq),
        .irq_id    (irq_id),
        .busy      (busy),
        .pending   (pending),
        .overrun   (overrun)
    );

    // Reference state
    int m_period [N_CH];
    int m_since  [N_CH];
    bit m_en     [N_CH];
    bit m_pend   [N_CH];
    bit m_ovr    [N_CH];
    int m_pw, m_id, m_age, m_pwl, m_ptr;
    bit m_busy;

    task automatic model_reset();
        for (int k = 0; k < N_CH; k++) begin
            m_period[k] = 0; m_since[k] = 0; m_en[k] = 0; m_pend[k] = 0; m_ovr[k] = 0;
        end
        m_pw = 100; m_id = 0; m_age = 0; m_pwl = 1; m_ptr = N_CH - 1; m_busy = 0;
    endtask

    task automatic model_step();
        bit tk [N_CH];
        bit hit, mine;
        int g, c;
        hit = ack && m_busy && (int'(ack_id) == m_id);
        g = -1;
        if (!m_busy)
            for (int i = 1; i <= N_CH; i++) begin
                c = (m_ptr + i) % N_CH;
                if (g < 0 && m_pend[c]) g = c;
            end
        for (int k = 0; k < N_CH; k++)
            tk[k] = m_en[k] && m_period[k] > 0 && (m_since[k] % m_period[k] == m_period[k] - 1);
        for (int k = 0; k < N_CH; k++) begin
            mine = m_busy && m_id == k;
            if (cfg_we && cfg_addr == 6 && cfg_wdata[k]) m_ovr[k] = 0;
            if (tk[k]) begin
                if (m_pend[k] && !(hit && mine)) m_ovr[k] = 1;
                m_pend[k] = 1;
            end else if (hit && mine) begin
                m_pend[k] = 0;
            end
            if (!m_en[k] && !mine) m_pend[k] = 0;
            if (cfg_we && (cfg_addr == k || (cfg_addr == 4 && cfg_wdata[k] && !m_en[k])))
                m_since[k] = 0;
            else if (m_en[k] && m_period[k] > 0)
                m_since[k]++;
            else
                m_since[k] = 0;
        end
        if (m_busy) begin
            if (hit) m_busy = 0;
            else if (m_age < 100000) m_age++;
        end else if (g >= 0) begin
            m_busy = 1; m_id = g; m_ptr = g; m_age = 1;
            m_pwl = (m_pw == 0) ? 1 : m_pw;
        end
        if (cfg_we) begin
            for (int k = 0; k < N_CH; k++)
                if (cfg_addr == k) m_period[k] = int'(cfg_wdata);
            if (cfg_addr == 4)
                for (int k = 0; k < N_CH; k++) m_en[k] = cfg_wdata[k];
            if (cfg_addr == 5) m_pw = int'(cfg_wdata[PW_W-1:0]);
        end
    endtask

    always @(posedge clk_100 or negedge rstn_100) begin
        if (!rstn_100) model_reset();
        else model_step();
    end

    task automatic check_model(input string tag);
        logic            e_irq;
        logic [1:0]      e_id;
        logic [N_CH-1:0] e_pend, e_ovr;
        e_irq = m_busy && m_age >= 2 && m_age <= m_pwl + 1;
        e_id  = 2'(m_id);
        for (int k = 0; k < N_CH; k++) begin
            e_pend[k] = m_pend[k];
            e_ovr[k]  = m_ovr[k];
        end
        checks++;
        assert (irq === e_irq) else begin errors++; $error("FAIL %s_irq cyc %0d got %b required %b", tag, cyc_no, irq, e_irq); end
        checks++;
        assert (irq_id === e_id) else begin errors++; $error("FAIL %s_irq_id cyc %0d got %0d required %0d", tag, cyc_no, irq_id, e_id); end
        checks++;
        assert (busy === m_busy) else begin errors++; $error("FAIL %s_busy cyc %0d got %b required %b", tag, cyc_no, busy, m_busy); end
        checks++;
        assert (pending === e_pend) else begin errors++; $error("FAIL %s_pending cyc %0d got %b required %b", tag, cyc_no, pending, e_pend); end
        checks++;
        assert (overrun === e_ovr) else begin errors++; $error("FAIL %s_overrun cyc %0d got %b required %b", tag, cyc_no, overrun, e_ovr); end
    endtask

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin errors++; $error("FAIL %s got %0d required %0d", tag, got, exp); end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_100);
            #1;
            cyc_no++;
            check_model("model");
        end
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [CNT_W-1:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        step(1);
        cfg_we = 1'b0;
    endtask

    task automatic do_ack(input logic [1:0] id);
        ack = 1'b1; ack_id = id;
        step(1);
        ack = 1'b0;
    endtask

    task automatic wait_level(input string tag, input logic lvl, input int max_cyc);
        int n;
        n = 0;
        while (irq !== lvl && n < max_cyc) begin
            step(1);
            n++;
        end
        checks++;
        assert (irq === lvl) else begin errors++; $error("FAIL %s timeout irq got %b required %b", tag, irq, lvl); end
    endtask

    task automatic do_reset();
        rstn_100 = 1'b0; ack = 1'b0; cfg_we = 1'b0;
        #3;
        rstn_100 = 1'b1;
        step(1);
    endtask

    initial begin
        int last_rise, w, rises;
        logic prev_irq;
        logic [1:0] exp_order [5];

        // Reset values while reset is held
        #3;
        expect_eq("rst_irq", 32'(irq), 0);
        expect_eq("rst_irq_id", 32'(irq_id), 0);
        expect_eq("rst_busy", 32'(busy), 0);
        expect_eq("rst_pending", 32'(pending), 0);
        expect_eq("rst_overrun", 32'(overrun), 0);
        @(negedge clk_100);
        rstn_100 = 1'b1;
        step(1);

        // Single channel, period 10, PW 5; ack lands on the next tick cycle
        cfg_write(3'd0, 24'd10);
        cfg_write(3'd5, 24'd5);
        cfg_write(3'd4, 24'd1);
        last_rise = 0;
        for (int r = 0; r < 3; r++) begin
            wait_level("p10_rise", 1'b1, 40);
            if (r > 0) expect_eq("p10_interval", 32'(cyc_no - last_rise), 10);
            last_rise = cyc_no;
            expect_eq("p10_irq_id", 32'(irq_id), 0);
            w = 0;
            while (irq === 1'b1 && w < 50) begin
                w++;
                step(1);
            end
            expect_eq("p10_width", 32'(w), 5);
            step(2);
            do_ack(2'd0);
            expect_eq("tick_ack_pending0", 32'(pending[0]), 1);
            expect_eq("tick_ack_overrun0", 32'(overrun[0]), 0);
            expect_eq("tick_ack_busy", 32'(busy), 0);
        end

        // Four channels ticking together are served in rotation
        do_reset();
        cfg_write(3'd5, 24'd2);
        for (int k = 0; k < N_CH; k++) cfg_write(3'(k), 24'd20);
        cfg_write(3'd4, 24'hF);
        exp_order[0] = 2'd0; exp_order[1] = 2'd1; exp_order[2] = 2'd2;
        exp_order[3] = 2'd3; exp_order[4] = 2'd0;
        for (int i = 0; i < 5; i++) begin
            wait_level("rr_rise", 1'b1, 60);
            expect_eq("rr_order", 32'(irq_id), 32'(exp_order[i]));
            wait_level("rr_fall", 1'b0, 20);
            do_ack(irq_id);
            expect_eq("rr_busy_after_ack", 32'(busy), 0);
        end

        // Unacknowledged channel 1 overruns; foreign ack ignored; W1C clears
        do_reset();
        cfg_write(3'd5, 24'd4);
        cfg_write(3'd1, 24'd8);
        cfg_write(3'd4, 24'd2);
        wait_level("ovr_rise", 1'b1, 30);
        rises = 0;
        prev_irq = irq;
        for (int i = 0; i < 24; i++) begin
            step(1);
            if (irq === 1'b1 && prev_irq === 1'b0) rises++;
            prev_irq = irq;
        end
        expect_eq("ovr_single_irq", 32'(rises), 0);
        expect_eq("ovr_flag1", 32'(overrun[1]), 1);
        expect_eq("ovr_irq_id", 32'(irq_id), 1);
        do_ack(2'd2);
        expect_eq("wrong_ack_busy", 32'(busy), 1);
        do_ack(2'd1);
        expect_eq("right_ack_busy", 32'(busy), 0);
        cfg_write(3'd4, 24'd0);
        cfg_write(3'd6, 24'h2);
        expect_eq("ovr_w1c", 32'(overrun[1]), 0);

        // Reset asserted during the second cycle of a 5-cycle pulse
        do_reset();
        cfg_write(3'd0, 24'd10);
        cfg_write(3'd5, 24'd5);
        cfg_write(3'd4, 24'd1);
        wait_level("rstmid_rise", 1'b1, 40);
        step(1);
        expect_eq("rstmid_pulse_high", 32'(irq), 1);
        #3;
        rstn_100 = 1'b0;
        #1;
        expect_eq("rstmid_irq", 32'(irq), 0);
        expect_eq("rstmid_irq_id", 32'(irq_id), 0);
        expect_eq("rstmid_busy", 32'(busy), 0);
        expect_eq("rstmid_pending", 32'(pending), 0);
        expect_eq("rstmid_overrun", 32'(overrun), 0);
        #2;
        rstn_100 = 1'b1;
        step(3);

        // Randomized traffic against the reference
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            cfg_we   = ($urandom_range(0, 7) == 0);
            cfg_addr = 3'($urandom_range(0, 7));
            case (cfg_addr)
                3'd4:    cfg_wdata = CNT_W'($urandom_range(0, 15));
                3'd5:    cfg_wdata = CNT_W'($urandom_range(0, 6));
                3'd6:    cfg_wdata = CNT_W'($urandom_range(0, 15));
                3'd7:    cfg_wdata = CNT_W'($urandom);
                default: cfg_wdata = CNT_W'($urandom_range(0, 12));
            endcase
            ack    = ($urandom_range(0, 3) == 0);
            ack_id = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'(m_id);
            step(1);
        end
        cfg_we = 1'b0;
        ack    = 1'b0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_irq_scheduler.md
TIMER_IRQ_SCHEDULER -- requirements
Module: timer_irq_scheduler

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of periodic timer channels.
REQ-002 SHALL have parameter CNT_W, default 24, width of each period counter.
REQ-003 SHALL have parameter PW_W, default 12, width of the pulse-width register.
REQ-004 SHALL have parameter PW_DEFAULT, default 100, reset value of pulse width in clk_100 cycles (100 = 1 us).
REQ-005 SHALL have port clk_100  in  1  sole clock, 100 MHz.
REQ-006 SHALL have port rstn_100  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port cfg_we  in  1  config write strobe, one cycle per write.
REQ-008 SHALL have port cfg_addr  in  3  config register index.
REQ-009 SHALL have port cfg_wdata  in  CNT_W  config write data.
REQ-010 SHALL have port ack  in  1  CPU acknowledge strobe.
REQ-011 SHALL have port ack_id  in  clog2(N_CH)  channel being acknowledged.
REQ-012 SHALL have port irq  out  1  interrupt pulse to MicroBlaze.
REQ-013 SHALL have port irq_id  out  clog2(N_CH)  channel owning the current or last interrupt.
REQ-014 SHALL have port busy  out  1  high from grant until matching ack.
REQ-015 SHALL have port pending  out  N_CH  per-channel pending flags.
REQ-016 SHALL have port overrun  out  N_CH  sticky per-channel overrun flags.

Function
REQ-017 SHALL decode cfg_addr: 0..N_CH-1 = period of channel k; 4 = enable mask [N_CH-1:0]; 5 = pulse width [PW_W-1:0]; 6 = overrun write-1-to-clear; 7 = ignored.
REQ-018 SHALL make each enabled channel with period P >= 1 count 0..P-1 and produce a one-cycle tick at count P-1, wrapping to 0 (tick every P cycles).
REQ-019 SHALL treat period 0 as disabled; disabled channels hold count at 0 and produce no tick.
REQ-020 SHALL reset channel k's counter to 0 on the cycle following a write to its period or a 0->1 enable transition.
REQ-021 SHALL set pending[k] the cycle after tick k; a tick while pending[k] is already set also sets overrun[k].
REQ-022 SHALL implement FSM IDLE -> ASSERT -> WAIT_ACK -> IDLE.
REQ-023 SHALL, in IDLE with pending != 0, grant one channel round-robin (search starts at last grant + 1, mod N_CH), latch it into irq_id, set busy and enter ASSERT next cycle.
REQ-024 SHALL hold irq high for exactly PW cycles in ASSERT (PW = 0 treated as 1), then enter WAIT_ACK with irq low.
REQ-025 SHALL, on ack with ack_id == irq_id in ASSERT or WAIT_ACK, clear pending[irq_id], drop irq and busy next cycle and return to IDLE; ack with any other id, or in IDLE, SHALL be ignored.
REQ-026 SHALL, on tick and matching ack for the same channel in the same cycle, leave pending set and not set overrun.
REQ-027 SHALL clear pending[k] on disable, except for the granted channel while busy.
REQ-028 SHALL apply a pulse-width write only to the next grant, not to an in-progress pulse.
REQ-029 SHALL have at most one cycle from pending set to grant when IDLE (pending visible cycle t, irq high cycle t+2).

Reset
REQ-030 SHALL, while rstn_100 low, force irq=0, irq_id=0, busy=0, pending=0, overrun=0, all periods=0, enable=0, pulse width=PW_DEFAULT, counters=0, RR pointer=N_CH-1, FSM=IDLE.
REQ-031 SHALL abort an in-progress pulse or wait on reset assertion with no glitch beyond the reset edge.

Structure
REQ-032 SHALL place register address constants, FSM state encodings and PW_DEFAULT in shared package timer_irq_pkg.
REQ-033 SHALL implement the round-robin arbiter as sub-module rr_arbiter (request vector, pointer in, one-hot/index grant out).

Verification
REQ-034 SHALL test ch0 period=10, enable=1, PW=5, ack 3 cycles after irq falls -> irq high 5 cycles every 10 cycles, irq_id=0, overrun stays 0.
REQ-035 SHALL test ch0..3 period=20 enabled same cycle -> grants in order 0,1,2,3, each after previous ack; rotate start next round after last grant 3 -> 0.
REQ-036 SHALL test ch1 period=8, PW=4, no ack for 20 cycles -> overrun[1]=1, single irq; write 6 with 0x2 -> overrun[1]=0.
REQ-037 SHALL test ack with ack_id=2 while irq_id=1 -> ignored, busy stays 1; ack_id=1 -> busy=0 next cycle.
REQ-038 SHALL test tick and matching ack for ch0 in same cycle -> pending[0] remains 1, new irq granted, overrun[0]=0.
REQ-039 SHALL test rstn_100 low mid-pulse (cycle 2 of 5) -> irq=0 immediately, all outputs at reset values.
